mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory stage of the five-stage pipeline. It is the consumer of the execute-stage output register and the source of that stage's `stopm` stall.
- Issues single-beat load/store requests on the data bus, aligns and extends load data, and registers results toward writeback.
- Holds execute, via `stall_m`, for the whole life of a bus transaction.

Parameters:
- ADDR_W, 64, data bus address width.
- XLEN, 64, register/data width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- e_valid  in  1  execute output register holds a live instruction.
- e_pc  in  64  instruction PC.
- e_instr  in  32  raw instruction.
- e_result  in  64  ALU result; effective address for loads/stores.
- e_rd2  in  64  store data.
- e_dst  in  5  destination register.
- e_regwrite  in  1  instruction writes `e_dst`.
- e_memread  in  1  load.
- e_memwrite  in  1  store.
- e_size  in  2  access size: 0=B, 1=H, 2=W, 3=D.
- e_unsigned  in  1  zero-extend load.
- stall_m  out  1  hold execute output register (`stopm`).
- dreq_valid  out  1  bus request valid.
- dreq_addr  out  64  request address, low 3 bits forced to 0.
- dreq_write  out  1  1=store.
- dreq_strobe  out  8  byte enables.
- dreq_data  out  64  store data, lane-aligned.
- dresp_data_ok  in  1  transaction complete.
- dresp_data  in  64  read data, full doubleword.
- m_valid  out  1  writeback-bound instruction valid.
- m_pc  out  64  PC of that instruction.
- m_instr  out  32  raw instruction.
- m_dst  out  5  destination register.
- m_regwrite  out  1  register write enable.
- m_result  out  64  load data or passed-through ALU result.
- m_misalign  out  1  address misaligned; no access was made.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset → IDLE; every m_* output = 0; dreq_valid = 0; request registers = 0.
- A memory instruction is one with `e_valid & (e_memread | e_memwrite)`.
- Misaligned means: H with addr[0] ≠ 0, W with addr[1:0] ≠ 0, or D with addr[2:0] ≠ 0.

IDLE:
- Memory instruction, aligned: latch the request registers.
  - addr = {e_result[63:3], 3'b0}.
  - write = e_memwrite.
  - strobe = (size mask 0x01/0x03/0x0F/0xFF) << e_result[2:0].
  - data = e_rd2 << (8*e_result[2:0]).
  - Also latch offset, size and unsigned.
  - Go to BUSY with stall_m = 1. No dreq_valid in this cycle.
- Anything else (non-memory, misaligned, or e_valid = 0): stall_m = 0; the output register updates this edge.

BUSY:
- dreq_valid = 1 and all dreq_* come from the request registers, stable until completion. stall_m = 1.
- On dresp_data_ok: ld_raw <= dresp_data; go to DONE.
- dresp_data_ok is ignored in every state other than BUSY.

DONE:
- dreq_valid = 0; stall_m = 0. The output register updates this edge; go to IDLE.
- Because execute is still holding the same instruction in DONE, no new request is issued from DONE.

Output register (updates only on edges where stall_m = 0, otherwise holds):
- m_valid <= e_valid.
- m_pc, m_instr, m_dst <= e_*.
- m_regwrite <= e_regwrite & ~misalign.
- m_misalign <= e_valid & mem & misalign.
- m_result for a load = extract(ld_raw >> 8*offset, size, unsigned). Sign extension uses the top bit of the selected width; D is passed through unchanged.
- m_result for a store or non-memory instruction = e_result.
- When e_valid = 0, m_valid <= 0 and the other fields are don't-care.

Latency:
- Non-memory and misaligned instructions: 1 cycle.
- Memory access: 3 cycles minimum (IDLE, BUSY, DONE) when dresp_data_ok arrives in the first BUSY cycle; +1 cycle per BUSY wait cycle.

Boundary rules:
- e_* changing while BUSY has no effect, because requests use latched copies.
- Reset mid-BUSY: IDLE next cycle and dreq_valid = 0. The bus slave is reset in the same cycle and no response is expected.
- Byte store at offset 7: strobe = 0x80, data = rd2[7:0] in bits [63:56].

Test Plan:
- ALU instruction, e_result = 0x1234, e_regwrite = 1 → stall_m = 0 and no dreq. Next cycle m_valid = 1, m_result = 0x1234.
- LB at 0x1007 with unsigned = 0, slave returns 0x80xx_xxxx_xxxx_xxxx after 2 wait cycles → dreq_addr = 0x1000; stall_m high for 4 cycles; m_result = 0xFFFF_FFFF_FFFF_FF80.
- SH at 0x2002 with rd2 = 0xABCD → dreq_write = 1, strobe = 0x0C, data[31:16] = 0xABCD; request held stable until data_ok; m_regwrite = 0.
- LW at 0x3002 → no dreq_valid ever; 1-cycle latency; m_misalign = 1, m_regwrite = 0.
- Back-to-back LD, LD with data_ok in the first BUSY cycle → each takes 3 cycles, no request is overlapped or duplicated, and the second request's address matches the second instruction.
- Reset asserted in BUSY → next cycle state IDLE, dreq_valid = 0, m_valid = 0; a later data_ok pulse is ignored.

Source files
------------

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory stage: single-beat load/store bus access, load alignment/extension, writeback register
module mem_access #(
  parameter int ADDR_W = 64,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              e_valid,
  input  logic [63:0]       e_pc,
  input  logic [31:0]       e_instr,
  input  logic [XLEN-1:0]   e_result,
  input  logic [XLEN-1:0]   e_rd2,
  input  logic [4:0]        e_dst,
  input  logic              e_regwrite,
  input  logic              e_memread,
  input  logic              e_memwrite,
  input  logic [1:0]        e_size,
  input  logic              e_unsigned,
  output logic              stall_m,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic              dreq_write,
  output logic [7:0]        dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data,
  output logic              m_valid,
  output logic [63:0]       m_pc,
  output logic [31:0]       m_instr,
  output logic [4:0]        m_dst,
  output logic              m_regwrite,
  output logic [XLEN-1:0]   m_result,
  output logic              m_misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [7:0]        req_strobe;
  logic [XLEN-1:0]   req_data;
  logic [2:0]        req_off;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [XLEN-1:0]   ld_raw;

  logic            is_mem;
  logic            misalign;
  logic            mis_mem;
  logic [7:0]      size_mask;
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_ext;

  assign is_mem = e_valid & (e_memread | e_memwrite);

  always_comb begin
    misalign  = 1'b0;
    size_mask = 8'h01;
    case (e_size)
      2'd0: begin misalign = 1'b0;                  size_mask = 8'h01; end
      2'd1: begin misalign = e_result[0];           size_mask = 8'h03; end
      2'd2: begin misalign = |e_result[1:0];        size_mask = 8'h0F; end
      default: begin misalign = |e_result[2:0];     size_mask = 8'hFF; end
    endcase
  end

  assign mis_mem = is_mem & misalign;

  always_comb begin
    state_nxt = state;
    stall_m   = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem && !misalign) begin
          stall_m   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall_m = 1'b1;
        if (dresp_data_ok) state_nxt = DONE;
      end
      DONE: begin
        // execute still holds the same instruction here, so never re-issue it
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr     <= '0;
      req_write    <= 1'b0;
      req_strobe   <= '0;
      req_data     <= '0;
      req_off      <= '0;
      req_size     <= '0;
      req_unsigned <= 1'b0;
      ld_raw       <= '0;
    end else begin
      if (state == IDLE && is_mem && !misalign) begin
        req_addr     <= {e_result[ADDR_W-1:3], 3'b000};
        req_write    <= e_memwrite;
        req_strobe   <= size_mask << e_result[2:0];
        req_data     <= e_rd2 << {e_result[2:0], 3'b000};
        req_off      <= e_result[2:0];
        req_size     <= e_size;
        req_unsigned <= e_unsigned;
      end
      if (state == BUSY && dresp_data_ok) ld_raw <= dresp_data;
    end
  end

  assign dreq_valid  = (state == BUSY);
  assign dreq_addr   = req_addr;
  assign dreq_write  = req_write;
  assign dreq_strobe = req_strobe;
  assign dreq_data   = req_data;

  always_comb begin
    ld_shift = ld_raw >> {req_off, 3'b000};
    ld_ext   = ld_shift;
    case (req_size)
      2'd0: ld_ext = req_unsigned ? {{(XLEN-8){1'b0}}, ld_shift[7:0]}
                                  : {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      2'd1: ld_ext = req_unsigned ? {{(XLEN-16){1'b0}}, ld_shift[15:0]}
                                  : {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      2'd2: ld_ext = req_unsigned ? {{(XLEN-32){1'b0}}, ld_shift[31:0]}
                                  : {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // Only DONE carries a completed load; every other accepted instruction passes e_result.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid    <= 1'b0;
      m_pc       <= '0;
      m_instr    <= '0;
      m_dst      <= '0;
      m_regwrite <= 1'b0;
      m_result   <= '0;
      m_misalign <= 1'b0;
    end else if (!stall_m) begin
      m_valid    <= e_valid;
      m_pc       <= e_pc;
      m_instr    <= e_instr;
      m_dst      <= e_dst;
      m_regwrite <= e_regwrite & ~mis_mem;
      m_misalign <= mis_mem;
      m_result   <= (state == DONE && !req_write) ? ld_ext : e_result;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard bench for mem_access
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [63:0] e_pc;
  logic [31:0] e_instr;
  logic [63:0] e_result;
  logic [63:0] e_rd2;
  logic [4:0]  e_dst;
  logic        e_regwrite;
  logic        e_memread;
  logic        e_memwrite;
  logic [1:0]  e_size;
  logic        e_unsigned;
  logic        stall_m;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic        dreq_write;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        m_valid;
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [4:0]  m_dst;
  logic        m_regwrite;
  logic [63:0] m_result;
  logic        m_misalign;

  logic slave_ok = 1'b0;
  logic extra_ok = 1'b0;
  assign dresp_data_ok = slave_ok | extra_ok;

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(64), .XLEN(64)) dut (
    .clk(clk), .reset(reset),
    .e_valid(e_valid), .e_pc(e_pc), .e_instr(e_instr), .e_result(e_result), .e_rd2(e_rd2),
    .e_dst(e_dst), .e_regwrite(e_regwrite), .e_memread(e_memread), .e_memwrite(e_memwrite),
    .e_size(e_size), .e_unsigned(e_unsigned), .stall_m(stall_m),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_write(dreq_write),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .m_valid(m_valid), .m_pc(m_pc), .m_instr(m_instr), .m_dst(m_dst),
    .m_regwrite(m_regwrite), .m_result(m_result), .m_misalign(m_misalign)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  dst;
    logic        regwrite;
    logic [63:0] result;
    logic        misalign;
    logic        chk_result;
  } m_exp_t;

  typedef struct {
    logic [63:0] addr;
    logic        write;
    logic [7:0]  strobe;
    logic [63:0] data;
    int          waits;
    logic [63:0] rdata;
  } req_exp_t;

  m_exp_t   exp_m[$];
  req_exp_t exp_req[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic m_exp_t mk_m(input logic [63:0] pc, input logic [31:0] instr, input logic [4:0] dst,
                                  input logic rw, input logic [63:0] res, input logic mis, input logic cr);
    m_exp_t m;
    m.pc = pc; m.instr = instr; m.dst = dst; m.regwrite = rw;
    m.result = res; m.misalign = mis; m.chk_result = cr;
    return m;
  endfunction

  function automatic req_exp_t mk_r(input logic [63:0] addr, input logic wr, input logic [7:0] strb,
                                    input logic [63:0] data, input int waits, input logic [63:0] rdata);
    req_exp_t r;
    r.addr = addr; r.write = wr; r.strobe = strb; r.data = data; r.waits = waits; r.rdata = rdata;
    return r;
  endfunction

  // Bus slave and request checker: one expected request per BUSY episode, held stable throughout.
  bit       active = 0;
  int       wcnt = 0;
  req_exp_t cur;
  always @(negedge clk) begin
    if (dreq_valid === 1'b1) begin
      if (!active) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req actual=addr %h required=no request", dreq_addr);
          cur = mk_r(dreq_addr, dreq_write, dreq_strobe, dreq_data, 0, 64'h0);
        end else begin
          cur = exp_req.pop_front();
        end
        active = 1;
        wcnt = cur.waits;
      end
      chk("dreq_addr", dreq_addr, cur.addr);
      chk("dreq_write", {63'b0, dreq_write}, {63'b0, cur.write});
      chk("dreq_strobe", {56'b0, dreq_strobe}, {56'b0, cur.strobe});
      chk("dreq_data", dreq_data, cur.data);
      if (wcnt == 0) begin
        slave_ok   = 1'b1;
        dresp_data = cur.rdata;
      end else begin
        slave_ok = 1'b0;
        wcnt--;
      end
    end else begin
      active   = 0;
      slave_ok = 1'b0;
    end
  end

  // Writeback monitor: an instruction accepted at a posedge shows on m_* at the following negedge.
  bit pend = 0;
  always @(negedge clk) begin
    if (pend) begin
      if (exp_m.size() == 0) begin
        checks++; errors++;
        $display("FAIL m_unexpected actual=pc %h required=no output", m_pc);
      end else begin
        m_exp_t e;
        e = exp_m.pop_front();
        chk("m_valid", {63'b0, m_valid}, 64'd1);
        chk("m_pc", m_pc, e.pc);
        chk("m_instr", {32'b0, m_instr}, {32'b0, e.instr});
        chk("m_dst", {59'b0, m_dst}, {59'b0, e.dst});
        chk("m_regwrite", {63'b0, m_regwrite}, {63'b0, e.regwrite});
        chk("m_misalign", {63'b0, m_misalign}, {63'b0, e.misalign});
        if (e.chk_result) chk("m_result", m_result, e.result);
      end
    end
    pend = (stall_m === 1'b0) && (reset === 1'b0) && (e_valid === 1'b1);
  end

  task automatic issue(input m_exp_t em, input logic [63:0] e_res, input logic [63:0] rd2,
                       input logic e_rw, input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input int exp_stall, input logic has_req, input req_exp_t er);
    int  stalls;
    bit  accepted;
    exp_m.push_back(em);
    if (has_req) exp_req.push_back(er);
    e_valid = 1'b1; e_pc = em.pc; e_instr = em.instr; e_result = e_res; e_rd2 = rd2;
    e_dst = em.dst; e_regwrite = e_rw; e_memread = rd; e_memwrite = wr;
    e_size = size; e_unsigned = uns;
    stalls = 0;
    accepted = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (stall_m === 1'b0) begin
        accepted = 1;
        break;
      end
      stalls++;
    end
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=%0d cycles required=accept", stalls);
    end
    chk("stall_cycles", 64'(stalls), 64'(exp_stall));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    e_valid = 1'b0; e_memread = 1'b0; e_memwrite = 1'b0; e_regwrite = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    req_exp_t nr;
    bit seen;
    nr = mk_r(64'h0, 1'b0, 8'h0, 64'h0, 0, 64'h0);
    reset = 1'b1; e_valid = 1'b0; e_pc = '0; e_instr = '0; e_result = '0; e_rd2 = '0;
    e_dst = '0; e_regwrite = 1'b0; e_memread = 1'b0; e_memwrite = 1'b0; e_size = '0;
    e_unsigned = 1'b0; dresp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", {63'b0, m_valid}, 64'd0);
    chk("rst_dreq_valid", {63'b0, dreq_valid}, 64'd0);
    chk("rst_stall", {63'b0, stall_m}, 64'd0);
    chk("rst_m_result", m_result, 64'd0);
    chk("rst_dreq_addr", dreq_addr, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    // ALU op
    issue(mk_m(64'h100, 32'h0000_0013, 5'd5, 1'b1, 64'h1234, 1'b0, 1'b1),
          64'h1234, 64'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b0, nr);
    // LB signed at 0x1007, two wait cycles
    issue(mk_m(64'h104, 32'h0070_0003, 5'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b1),
          64'h1007, 64'h77, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4, 1'b1,
          mk_r(64'h1000, 1'b0, 8'h80, 64'h7700_0000_0000_0000, 2, 64'h80AA_BBCC_DDEE_FF11));
    // SH at 0x2002, one wait cycle
    issue(mk_m(64'h108, 32'h0011_1023, 5'd0, 1'b0, 64'h2002, 1'b0, 1'b1),
          64'h2002, 64'hABCD, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 3, 1'b1,
          mk_r(64'h2000, 1'b1, 8'h0C, 64'h0000_0000_ABCD_0000, 1, 64'h0));
    // LW misaligned: no bus traffic
    issue(mk_m(64'h10C, 32'h0020_2003, 5'd7, 1'b0, 64'h0, 1'b1, 1'b0),
          64'h3002, 64'h0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 0, 1'b0, nr);
    // back-to-back LD, response in first BUSY cycle
    issue(mk_m(64'h110, 32'h0000_3003, 5'd8, 1'b1, 64'h1122_3344_5566_7788, 1'b0, 1'b1),
          64'h4000, 64'h0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 2, 1'b1,
          mk_r(64'h4000, 1'b0, 8'hFF, 64'h0, 0, 64'h1122_3344_5566_7788));
    issue(mk_m(64'h114, 32'h0080_3003, 5'd9, 1'b1, 64'h8877_6655_4433_2211, 1'b0, 1'b1),
          64'h4008, 64'h0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 2, 1'b1,
          mk_r(64'h4008, 1'b0, 8'hFF, 64'h0, 0, 64'h8877_6655_4433_2211));
    // LHU at offset 6
    issue(mk_m(64'h118, 32'h0000_5003, 5'd10, 1'b1, 64'h0000_0000_0000_BEEF, 1'b0, 1'b1),
          64'h5006, 64'h0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 2, 1'b1,
          mk_r(64'h5000, 1'b0, 8'hC0, 64'h0, 0, 64'hBEEF_1111_2222_3333));
    // LW signed at offset 4, three wait cycles
    issue(mk_m(64'h11C, 32'h0000_2003, 5'd11, 1'b1, 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b1),
          64'h6004, 64'h0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5, 1'b1,
          mk_r(64'h6000, 1'b0, 8'hF0, 64'h0, 3, 64'h8000_0001_DEAD_BEEF));
    // SB at offset 7
    issue(mk_m(64'h120, 32'h0000_0023, 5'd0, 1'b0, 64'h7007, 1'b0, 1'b1),
          64'h7007, 64'h1234_565A, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2, 1'b1,
          mk_r(64'h7000, 1'b1, 8'h80, 64'h5A00_0000_0000_0000, 0, 64'h0));
    idle(2);

    // reset while BUSY; the slave never answers this one
    exp_req.push_back(mk_r(64'h8000, 1'b0, 8'hFF, 64'h0, 50, 64'h0));
    e_valid = 1'b1; e_pc = 64'h124; e_instr = 32'h0000_3003; e_result = 64'h8000; e_rd2 = '0;
    e_dst = 5'd12; e_regwrite = 1'b1; e_memread = 1'b1; e_memwrite = 1'b0; e_size = 2'd3;
    e_unsigned = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dreq_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk("busy_reached", {63'b0, seen}, 64'd1);
    reset = 1'b1;
    e_valid = 1'b0; e_memread = 1'b0; e_regwrite = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstbusy_dreq_valid", {63'b0, dreq_valid}, 64'd0);
    chk("rstbusy_m_valid", {63'b0, m_valid}, 64'd0);
    chk("rstbusy_stall", {63'b0, stall_m}, 64'd0);
    extra_ok = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_ok_dreq_valid", {63'b0, dreq_valid}, 64'd0);
      chk("stray_ok_stall", {63'b0, stall_m}, 64'd0);
      chk("stray_ok_m_valid", {63'b0, m_valid}, 64'd0);
    end
    extra_ok = 1'b0;
    @(posedge clk); #1;

    // pipeline still alive after the reset
    issue(mk_m(64'h200, 32'h0010_0093, 5'd1, 1'b1, 64'hCAFE, 1'b0, 1'b1),
          64'hCAFE, 64'h0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 0, 1'b0, nr);
    idle(4);

    chk("exp_m_drained", 64'(exp_m.size()), 64'd0);
    chk("exp_req_drained", 64'(exp_req.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
